// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the three sides of the memory arbiter.
//   IF side  : i_req, i_addr -> i_rdata, i_ready
//   MEM side : d_req, d_we, d_wmask, d_addr, d_wdata -> d_rdata, d_ready
//   RAM side : mem_req, mem_we, mem_wmask, mem_addr, mem_wdata <- mem_rdata, mem_ack
//   Debug    : owner (0 none, 1 IF, 2 MEM), bus_err (sticky timeout flag)
// Modport master is the arbiter itself; modport slave is its environment
// (CPU pipeline plus unified RAM).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic                d_req;
    logic                d_we;
    logic [DATA_W/8-1:0] d_wmask;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_ready;

    logic                mem_req;
    logic                mem_we;
    logic [DATA_W/8-1:0] mem_wmask;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    logic [1:0] owner;
    logic       bus_err;

    modport master (
        input  i_req, i_addr,
        output i_rdata, i_ready,
        input  d_req, d_we, d_wmask, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_req, mem_we, mem_wmask, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output owner, bus_err
    );

    modport slave (
        output i_req, i_addr,
        input  i_rdata, i_ready,
        output d_req, d_we, d_wmask, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_req, mem_we, mem_wmask, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  owner, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported unified memory between the CPU
// instruction-fetch (IF) and data-access (MEM) stages. Each access runs
// IDLE -> BUSY -> RESP: grant and latch the access, hold mem_req until
// mem_ack (or timeout), then pulse the owner's ready for one cycle.
// Ports:
//   clk  - rising-edge clock
//   rstn - synchronous active-low reset
//   bus  - mem_arbiter_if.master (IF, MEM, RAM and debug signals)
// All outputs come straight from registers.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          rstn,
    mem_arbiter_if.master bus
);
    localparam int MW = DATA_W / 8;
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_MEM  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [1:0]        owner_q,   owner_d;
    logic              we_q,      we_d;
    logic [MW-1:0]     wmask_q,   wmask_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic              mem_req_q, mem_req_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              bus_err_q, bus_err_d;
    logic [SW-1:0]     streak_q,  streak_d;
    logic [TW-1:0]     tmo_q,     tmo_d;

    logic grant_d;
    logic grant_i;
    logic streak_full;

    assign streak_full = (streak_q == SW'(MAX_D_STREAK));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_NONE;
            we_q      <= 1'b0;
            wmask_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_req_q <= 1'b0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            bus_err_q <= 1'b0;
            streak_q  <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            wmask_q   <= wmask_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mem_req_q <= mem_req_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            bus_err_q <= bus_err_d;
            streak_q  <= streak_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        wmask_d   = wmask_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_req_d = mem_req_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        bus_err_d = bus_err_q;
        streak_d  = streak_q;
        tmo_d     = tmo_q;
        grant_d   = 1'b0;
        grant_i   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // MEM has priority, except when it has already won
                // MAX_D_STREAK grants in a row while IF was waiting.
                grant_d = bus.d_req && !(bus.i_req && streak_full);
                grant_i = bus.i_req && !grant_d;
                if (grant_d) begin
                    owner_d   = OWN_MEM;
                    we_d      = bus.d_we;
                    wmask_d   = bus.d_wmask;
                    addr_d    = bus.d_addr;
                    wdata_d   = bus.d_wdata;
                    mem_req_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = S_BUSY;
                    if (!bus.i_req) begin
                        streak_d = '0;
                    end else if (!streak_full) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (grant_i) begin
                    owner_d   = OWN_IF;
                    we_d      = 1'b0;
                    wmask_d   = '0;
                    addr_d    = bus.i_addr;
                    wdata_d   = '0;
                    mem_req_d = 1'b1;
                    tmo_d     = '0;
                    streak_d  = '0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                // An ack in the last allowed cycle beats the timeout.
                if (bus.mem_ack) begin
                    if (owner_q == OWN_IF) begin
                        i_rdata_d = bus.mem_rdata;
                        i_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = bus.mem_rdata;
                        d_ready_d = 1'b1;
                    end
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // mem_req has now been high for TIMEOUT cycles.
                    if (owner_q == OWN_IF) begin
                        i_rdata_d = '0;
                        i_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = '0;
                        d_ready_d = 1'b1;
                    end
                    bus_err_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESP: begin
                // Ready is high this cycle; requests are not sampled here.
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                owner_d   = OWN_NONE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_wmask = wmask_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.owner     = owner_q;
    assign bus.bus_err   = bus_err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one memory arbiter that shares a single-ported unified memory between the CPU's instruction-fetch (IF) stage and data-access (MEM) stage. It sequences each access through a request/acknowledge handshake to the memory, returns read data to the winning requester, and signals completion so the pipeline can stall while waiting. It sits between the `CPU` pipeline and the unified RAM, replacing separate instruction and data memories.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_D_STREAK`, 4, consecutive data grants allowed while IF waits
- `TIMEOUT`, 255, cycles in BUSY without `mem_ack` before abort

- `clk`  in  1  clock, all logic on rising edge
- `rstn`  in  1  reset, synchronous, active-low
- `i_req`  in  1  IF request, level, held until `i_ready`
- `i_addr`  in  ADDR_W  IF address, stable while `i_req`
- `i_rdata`  out  DATA_W  IF read data, valid with `i_ready`
- `i_ready`  out  1  IF completion pulse, one cycle
- `d_req`  in  1  MEM request, level, held until `d_ready`
- `d_we`  in  1  1 = write
- `d_wmask`  in  DATA_W/8  byte enables for write
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_rdata`  out  DATA_W  data read data, valid with `d_ready`
- `d_ready`  out  1  MEM completion pulse, one cycle
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`, `mem_wmask`, `mem_addr`, `mem_wdata`  out  1/DATA_W/8/ADDR_W/DATA_W  latched access fields
- `mem_rdata`  in  DATA_W  memory read data, valid when `mem_ack`
- `mem_ack`  in  1  memory completion, one cycle
- `owner`  out  2  0 none, 1 IF, 2 MEM (debug)
- `bus_err`  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if no request, stay. If exactly one request, grant it. If both: grant MEM unless `d_streak == MAX_D_STREAK`, then grant IF. On grant latch owner, we (forced 0 for IF), wmask (0 for IF), addr, wdata into registers; go BUSY.
- `d_streak`: on MEM grant with `i_req`=1, increment (saturates at MAX_D_STREAK); on IF grant or MEM grant with `i_req`=0, clear.
- BUSY: `mem_req`=1, memory fields driven from latched registers. On `mem_ack`: capture `mem_rdata` into owner's rdata register, go RESP. Timeout counter increments each BUSY cycle; when it reaches TIMEOUT with no `mem_ack`, capture rdata = 0, set `bus_err`, go RESP.
- RESP: pulse owner's ready for exactly one cycle, `mem_req`=0; go IDLE. Requests are not sampled in RESP (requester updates its `req` on this edge).
- Writes also complete with `d_ready`; `d_rdata` then holds whatever memory returned.
- `i_rdata`/`d_rdata` hold last captured value until next capture for that port.
- `mem_ack` outside BUSY is ignored.
- Reset (`rstn`=0 at a rising edge, any state): state IDLE, `mem_req`, `i_ready`, `d_ready`, `bus_err`, `d_streak`, timeout counter, `owner` = 0; rdata registers = 0; in-flight access discarded with no ready pulse.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Request seen in IDLE at cycle 0 -> `mem_req` high cycle 1; `mem_ack` in cycle k>=1 -> ready high cycle k+1 -> IDLE cycle k+2.
- Minimum latency: request to ready = 2 cycles; back-to-back throughput = one access per 3 cycles.
- Timeout: `mem_req` high for TIMEOUT cycles, ready in cycle TIMEOUT+1.
- `mem_ack` and timeout in same cycle: `mem_ack` wins, `bus_err` unchanged.
- `bus_err` cleared only by reset.

## Test plan
- Reset: hold `rstn`=0 two cycles with `i_req`=`d_req`=1 -> all outputs 0, no `mem_req`; release -> `mem_req` rises one cycle later with owner=2.
- Single IF read: `i_addr`=0x80000000, memory acks first BUSY cycle with 0x00500093 -> `i_ready` pulses cycle 2, `i_rdata`=0x00500093, `mem_we`=0.
- Data write: `d_we`=1, `d_wmask`=0xF, `d_addr`=0x100, `d_wdata`=0xDEADBEEF, ack after 3 cycles -> memory fields match throughout BUSY, `d_ready` one cycle after ack.
- Starvation: `i_req` and `d_req` both held high continuously, ack every first cycle -> grant sequence MEM,MEM,MEM,MEM,IF repeating.
- Timeout: TIMEOUT=8, never ack -> `mem_req` high 8 cycles, `d_ready` pulse with `d_rdata`=0, `bus_err`=1 and stays 1 until reset.
- Reset mid-BUSY: assert `rstn`=0 while `mem_req`=1 -> next cycle `mem_req`=0, no ready pulse, late `mem_ack` ignored.
